stack_arbiter: RTL and testbench

- Synchronous controller that owns the 16-entry x 16-bit hardware stack and shares it between two requesters.
- Port A is the control unit, for CALL/RET return addresses. Port B is the datapath, for PUSH/POP instructions.
- Holds the only stack pointer, full and empty flags. Round-robin arbitration. Every request ends in a registered ack/err response.
- Replaces the global-variable pointer with a single clocked owner.

---
 rtl/stack_pkg.sv | 21 ++
 rtl/stack_mem.sv | 26 ++
 rtl/stack_arbiter.sv | 153 +++++++++++++++
 tb/tb_stack_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared constants and types for the two-port hardware stack controller.
package stack_pkg;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    // Operation encoding follows the rwb port polarity.
    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/stack_mem.sv
// Stack storage: synchronous write port and a registered read port.
module stack_mem #(
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    import stack_pkg::*;

    logic [DW-1:0] r_mem [DEPTH];

    // Contents are intentionally not reset; the pointer alone defines validity.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        rdata <= r_mem[raddr];
    end

endmodule

// File: rtl/stack_arbiter.sv
// Single owner of the stack pointer: round-robin arbitration between the
// control unit (port A) and the datapath (port B), one op per three cycles.
module stack_arbiter #(
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          req_a,
    input  logic          rwb_a,
    input  logic [DW-1:0] din_a,
    input  logic          req_b,
    input  logic          rwb_b,
    input  logic [DW-1:0] din_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          ack_a,
    output logic          ack_b,
    output logic          err,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    import stack_pkg::*;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_owner;
    logic          r_op;
    logic [DW-1:0] r_din;
    logic          r_last;
    logic          r_err;
    logic [AW:0]   r_count;

    logic          w_any_req;
    logic          w_pick;
    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_we;
    logic [AW-1:0] w_raddr;
    logic [DW-1:0] w_rdata;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);

    // Contested requests go to whichever port was not granted last.
    assign w_any_req = req_a | req_b;
    assign w_pick    = (req_a && req_b) ? ((r_last == OWN_B) ? OWN_A : OWN_B)
                                        : (req_a ? OWN_A : OWN_B);

    assign w_push_ok = (r_state == ACCESS) && (r_op == OP_PUSH) && !w_full;
    assign w_pop_ok  = (r_state == ACCESS) && (r_op == OP_POP)  && !w_empty;
    assign w_we      = w_push_ok && !flush && !rst;
    assign w_raddr   = r_count[AW-1:0] - AW'(1);

    stack_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_count[AW-1:0]),
        .wdata (r_din),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (flush) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_nxt = ACCESS;
            ACCESS:  w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        ack_a = 1'b0;
        ack_b = 1'b0;
        err   = 1'b0;
        dout  = '0;
        if (r_state == ACCESS || r_state == RESP) begin
            gnt_a = (r_owner == OWN_A);
            gnt_b = (r_owner == OWN_B);
        end
        if (r_state == RESP) begin
            ack_a = (r_owner == OWN_A);
            ack_b = (r_owner == OWN_B);
            err   = r_err;
            if (r_op == OP_POP && !r_err) begin
                dout = w_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_last  <= OWN_B;
            r_owner <= OWN_A;
            r_op    <= OP_PUSH;
            r_err   <= 1'b0;
        end else if (flush) begin
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == IDLE && w_any_req) begin
                r_owner <= w_pick;
                r_op    <= (w_pick == OWN_A) ? rwb_a : rwb_b;
                r_last  <= w_pick;
            end
            if (r_state == ACCESS) begin
                r_err <= !(w_push_ok || w_pop_ok);
                if (w_push_ok) begin
                    r_count <= r_count + (AW+1)'(1);
                end else if (w_pop_ok) begin
                    r_count <= r_count - (AW+1)'(1);
                end
            end
        end
    end

    // Push data is captured alongside the grant; it needs no reset.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_any_req) begin
            r_din <= (w_pick == OWN_A) ? din_a : din_b;
        end
    end

    assign full  = w_full;
    assign empty = w_empty;
    assign count = r_count;

endmodule

// File: tb/tb_stack_arbiter.sv
// Randomized and directed bench for stack_arbiter with a queue-based stack model.
module tb_stack_arbiter;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        req_a, rwb_a, req_b, rwb_b;
    logic [15:0] din_a, din_b, dout;
    logic        gnt_a, gnt_b, ack_a, ack_b, err, full, empty;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        port;
        logic        err;
        logic [15:0] dout;
        int          cnt;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_stack[$];
    int          m_phase = 0;
    int          m_prev  = 0;
    logic        m_owner = 1'b0;
    logic        m_last  = 1'b1;
    bit          m_live  = 1'b0;
    bit          rnd_done;

    stack_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .req_a (req_a),
        .rwb_a (rwb_a),
        .din_a (din_a),
        .req_b (req_b),
        .rwb_b (rwb_b),
        .din_b (din_b),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b),
        .ack_a (ack_a),
        .ack_b (ack_b),
        .err   (err),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each served request is one 3-cycle transaction on a plain LIFO queue.
    always @(posedge clk) begin
        if (rst) begin
            if (m_phase == 1 && sb.size() > 0) void'(sb.pop_back());
            m_phase = 0;
            m_stack.delete();
            m_last  = 1'b1;
            m_live  = 1'b1;
        end else if (m_live) begin
            if (flush) begin
                if (m_phase == 1 && sb.size() > 0) void'(sb.pop_back());
                m_phase = 0;
                m_stack.delete();
            end else if (m_phase == 0) begin
                if (req_a || req_b) begin
                    exp_t e;
                    logic op;
                    logic [15:0] d;
                    if (req_a && req_b) m_owner = ~m_last;
                    else                m_owner = req_b;
                    m_last = m_owner;
                    op = m_owner ? rwb_b : rwb_a;
                    d  = m_owner ? din_b : din_a;
                    m_prev = m_stack.size();
                    e.port = m_owner;
                    e.err  = 1'b0;
                    e.dout = 16'h0;
                    if (op == 1'b0) begin
                        if (m_stack.size() == 16) e.err = 1'b1;
                        else m_stack.push_back(d);
                    end else begin
                        if (m_stack.size() == 0) e.err = 1'b1;
                        else e.dout = m_stack.pop_back();
                    end
                    e.cnt = m_stack.size();
                    sb.push_back(e);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else begin
                m_phase = 0;
            end
        end
    end

    // Monitor: compares the DUT against the model every cycle, and pops the
    // scoreboard whenever an ack is presented.
    always @(negedge clk) begin
        if (m_live) begin
            int ec;
            ec = (m_phase == 1) ? m_prev : m_stack.size();
            chk("gnt_a", 32'(gnt_a), 32'(m_phase != 0 && m_owner == 1'b0));
            chk("gnt_b", 32'(gnt_b), 32'(m_phase != 0 && m_owner == 1'b1));
            chk("ack_a", 32'(ack_a), 32'(m_phase == 2 && m_owner == 1'b0));
            chk("ack_b", 32'(ack_b), 32'(m_phase == 2 && m_owner == 1'b1));
            chk("count", 32'(count), 32'(ec));
            chk("full",  32'(full),  32'(ec == 16));
            chk("empty", 32'(empty), 32'(ec == 0));
            if (ack_a || ack_b) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_port", 32'(ack_b), 32'(e.port));
                    chk("resp_err",  32'(err),   32'(e.err));
                    chk("resp_dout", 32'(dout),  32'(e.dout));
                    chk("resp_cnt",  32'(count), 32'(e.cnt));
                end
            end else begin
                chk("idle_err",  32'(err),  32'd0);
                chk("idle_dout", 32'(dout), 32'd0);
            end
        end
    end

    // Issue one op on port p (0=A, 1=B); returns cycles-to-ack and the response.
    task automatic op(input bit p, input logic rwb, input logic [15:0] d,
                      output int lat, output logic e, output logic [15:0] q);
        int n = 0;
        if (p) begin req_b = 1'b1; rwb_b = rwb; din_b = d; end
        else   begin req_a = 1'b1; rwb_a = rwb; din_a = d; end
        e = 1'b0;
        q = 16'h0;
        do begin
            @(negedge clk);
            n++;
        end while (!(p ? ack_b : ack_a) && n < 100);
        if (n >= 100) begin
            errors++;
            $display("FAIL ack_timeout port %0d got none want ack", p);
        end else begin
            e = err;
            q = dout;
        end
        lat = n;
        @(posedge clk);
        #1;
        if (p) req_b = 1'b0;
        else   req_a = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, lat2;
        logic        e;
        logic [15:0] q;
        rst = 1'b1; flush = 1'b0;
        req_a = 1'b0; rwb_a = 1'b0; din_a = '0;
        req_b = 1'b0; rwb_b = 1'b0; din_b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        @(posedge clk); #1;

        // Single push then pop on B
        op(1'b1, 1'b0, 16'h1234, lat, e, q);
        chk("push_b_lat", 32'(lat), 32'd3);
        chk("push_b_err", 32'(e), 32'd0);
        chk("push_b_cnt", 32'(count), 32'd1);
        op(1'b1, 1'b1, 16'h0, lat, e, q);
        chk("pop_b_dout", 32'(q), 32'h1234);
        chk("pop_b_empty", 32'(empty), 32'd1);

        // Simultaneous pushes: A wins the tie, B follows
        fork
            op(1'b0, 1'b0, 16'hAAAA, lat, e, q);
            begin
                int l2; logic e2; logic [15:0] q2;
                op(1'b1, 1'b0, 16'hBBBB, l2, e2, q2);
                lat2 = l2;
            end
        join
        chk("tie_a_lat", 32'(lat), 32'd3);
        chk("tie_b_lat", 32'(lat2), 32'd6);
        op(1'b0, 1'b1, 16'h0, lat, e, q);
        chk("lifo_1", 32'(q), 32'hBBBB);
        op(1'b0, 1'b1, 16'h0, lat, e, q);
        chk("lifo_2", 32'(q), 32'hAAAA);

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) op(1'b0, 1'b0, 16'(i), lat, e, q);
        chk("fill_full", 32'(full), 32'd1);
        op(1'b0, 1'b0, 16'hDEAD, lat, e, q);
        chk("ovf_err", 32'(e), 32'd1);
        chk("ovf_cnt", 32'(count), 32'd16);
        for (int i = 15; i >= 0; i--) begin
            op(1'b0, 1'b1, 16'h0, lat, e, q);
            chk("drain", 32'(q), 32'(i));
        end

        // Underflow on B
        op(1'b1, 1'b1, 16'h0, lat, e, q);
        chk("udf_err", 32'(e), 32'd1);
        chk("udf_dout", 32'(q), 32'd0);
        chk("udf_cnt", 32'(count), 32'd0);

        // Both ports requesting back-to-back: grants must alternate
        fork
            begin
                int l; logic ee; logic [15:0] qq;
                for (int i = 0; i < 4; i++) op(1'b0, 1'b0, 16'($urandom), l, ee, qq);
            end
            begin
                int l; logic ee; logic [15:0] qq;
                for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 16'($urandom), l, ee, qq);
            end
        join
        for (int i = 0; i < 8; i++) op(1'b0, 1'b1, 16'h0, lat, e, q);

        // Flush during ACCESS of a push with five entries stacked
        for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 16'h0100 + 16'(i), lat, e, q);
        fork
            op(1'b1, 1'b0, 16'h0055, lat, e, q);
            begin
                @(posedge clk); #1 flush = 1'b1;
                @(posedge clk); #1 flush = 1'b0;
                @(negedge clk);
                chk("flush_cnt", 32'(count), 32'd0);
                chk("flush_empty", 32'(empty), 32'd1);
            end
        join
        chk("flush_lat", 32'(lat), 32'd5);
        chk("flush_retry_cnt", 32'(count), 32'd1);

        // Reset during ACCESS: op abandoned, held request re-served afterwards
        fork
            op(1'b0, 1'b0, 16'h0077, lat, e, q);
            begin
                @(posedge clk); #1 rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                @(negedge clk);
                chk("rst_mid_cnt", 32'(count), 32'd0);
                chk("rst_mid_gnt", 32'(gnt_a), 32'd0);
            end
        join
        chk("rst_retry_cnt", 32'(count), 32'd1);

        // Randomized traffic on both ports with occasional flushes
        rnd_done = 1'b0;
        fork
            begin
                fork
                    begin
                        int l; logic ee; logic [15:0] qq;
                        for (int i = 0; i < 40; i++) begin
                            op(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), l, ee, qq);
                            repeat ($urandom_range(0, 2)) @(posedge clk);
                            #1;
                        end
                    end
                    begin
                        int l; logic ee; logic [15:0] qq;
                        for (int i = 0; i < 40; i++) begin
                            op(1'b1, 1'($urandom_range(0, 2) == 0), 16'($urandom), l, ee, qq);
                            repeat ($urandom_range(0, 2)) @(posedge clk);
                            #1;
                        end
                    end
                join
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    flush = ($urandom_range(0, 29) == 0);
                end
                flush = 1'b0;
            end
        join

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
